// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the external 16-bit asynchronous SRAM port.
//   - mode_e      : command codes issued by the SRAM access sequencer
//   - RDC_*       : rdSramCount read-phase codes
//   - state_e     : pin controller state machine
//   - decode_mode : maps raw 3-bit mode to a legal code (illegal -> idle)
//   - rd_lanes    : maps a read-phase code to its lane mask {UB, LB}
package sram_pkg;

  localparam int AW_DEFAULT = 20;

  typedef enum logic [2:0] {
    MODE_IDLE  = 3'b000,
    MODE_READ  = 3'b010,
    MODE_WR_LB = 3'b100,
    MODE_WR_UB = 3'b101
  } mode_e;

  localparam logic [1:0] RDC_EVEN_ALL = 2'b00;
  localparam logic [1:0] RDC_EVEN_LB  = 2'b01;
  localparam logic [1:0] RDC_ODD_UB   = 2'b10;
  localparam logic [1:0] RDC_ODD_ALL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_TURN
  } state_e;

  function automatic mode_e decode_mode(input logic [2:0] raw);
    case (raw)
      3'b010:  return MODE_READ;
      3'b100:  return MODE_WR_LB;
      3'b101:  return MODE_WR_UB;
      default: return MODE_IDLE;
    endcase
  endfunction

  // Bit0 = LB, bit1 = UB.
  function automatic logic [1:0] rd_lanes(input logic [1:0] cnt);
    case (cnt)
      RDC_EVEN_LB: return 2'b01;
      RDC_ODD_UB:  return 2'b10;
      default:     return 2'b11;  // RDC_EVEN_ALL, RDC_ODD_ALL
    endcase
  endfunction

endpackage

// File: rtl/sram_port_ctrl_if.sv
// sram_port_ctrl_if: pin bundle of the external asynchronous SRAM.
//   master : controller side, drives address/strobes/write data, reads pads
//   slave  : SRAM (or model) side
// All strobes are active-low; sram_dq_oe = 1 means the FPGA drives the bus.
interface sram_port_ctrl_if
  import sram_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) ();
  logic [AW-1:0] sram_addr;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic          sram_lb_n;
  logic          sram_ub_n;
  logic [15:0]   sram_dq_o;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_i;

  modport master (
    output sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
    output sram_dq_o, sram_dq_oe,
    input  sram_dq_i
  );

  modport slave (
    input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
    input  sram_dq_o, sram_dq_oe,
    output sram_dq_i
  );
endinterface

// File: rtl/sram_rd_capture.sv
// sram_rd_capture: read return path.
//   issue/issue_lanes : a read is being placed on the pins at the coming edge
//   dq_i              : SRAM pad data
//   rd_data/rd_mask/rd_valid : captured word, disabled lanes forced to 0
// issue is delayed one cycle to line up with the pin cycle, then the pads are
// sampled at the end of that pin cycle.
module sram_rd_capture (
  input  logic        clk100m,
  input  logic        rst,
  input  logic        issue,
  input  logic [1:0]  issue_lanes,
  input  logic [15:0] dq_i,
  output logic [15:0] rd_data,
  output logic [1:0]  rd_mask,
  output logic        rd_valid
);
  logic        issue_q, issue_d;
  logic [1:0]  lanes_q, lanes_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [1:0]  rd_mask_q, rd_mask_d;
  logic        rd_valid_q, rd_valid_d;

  always_comb begin
    issue_d    = issue;
    lanes_d    = issue_lanes;
    rd_valid_d = issue_q;
    rd_mask_d  = issue_q ? lanes_q : 2'b00;
    rd_data_d  = issue_q ? (dq_i & {{8{lanes_q[1]}}, {8{lanes_q[0]}}}) : 16'h0000;
  end

  always_ff @(posedge clk100m) begin
    if (rst) begin
      issue_q    <= 1'b0;
      lanes_q    <= 2'b00;
      rd_data_q  <= 16'h0000;
      rd_mask_q  <= 2'b00;
      rd_valid_q <= 1'b0;
    end else begin
      issue_q    <= issue_d;
      lanes_q    <= lanes_d;
      rd_data_q  <= rd_data_d;
      rd_mask_q  <= rd_mask_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_mask  = rd_mask_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: pin-level responder for the external 16-bit async SRAM.
//   clk100m, rst       : clock, synchronous active-high reset
//   mode, rdSramCount  : command stream from the access sequencer
//   rd_addr            : read word address, sampled with each read command
//   wr_start, wr_byte  : write address clear pulse, write data byte
//   sram               : SRAM pin bundle (master side)
//   rd_data/rd_mask/rd_valid : captured read words
//   wr_done            : pulse after each UB write strobe
// Every pin is a flop; the next pin values are computed from the current
// command and state.
module sram_port_ctrl
  import sram_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic             clk100m,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [1:0]       rdSramCount,
  input  logic [AW-1:0]    rd_addr,
  input  logic             wr_start,
  input  logic [7:0]       wr_byte,
  sram_port_ctrl_if.master sram,
  output logic [15:0]      rd_data,
  output logic [1:0]       rd_mask,
  output logic             rd_valid,
  output logic             wr_done
);
  state_e        state_q, state_d;
  mode_e         prev_mode_q, prev_mode_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic          lb_n_q, lb_n_d, ub_n_q, ub_n_d;
  logic [15:0]   dq_o_q, dq_o_d;
  logic          dq_oe_q, dq_oe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          wr_done_q, wr_done_d;
  // A read that had to wait behind a turnaround cycle.
  logic          pend_q, pend_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [1:0]    pend_lanes_q, pend_lanes_d;

  mode_e         mode_cur;
  logic          is_wr, phase_start, in_wr, ub_strobe;
  logic          issue;
  logic [1:0]    issue_lanes;

  always_comb begin
    mode_cur    = decode_mode(mode);
    is_wr       = (mode_cur == MODE_WR_LB) || (mode_cur == MODE_WR_UB);
    phase_start = is_wr && (mode_cur != prev_mode_q);
    in_wr       = (state_q == ST_WR_SETUP) || (state_q == ST_WR_STROBE);
    ub_strobe   = (state_q == ST_WR_STROBE) && !we_n_q && !ub_n_q;

    // Clear has priority over the post-UB increment.
    wr_addr_d   = wr_start ? '0 : (ub_strobe ? wr_addr_q + AW'(1) : wr_addr_q);
    wr_done_d   = ub_strobe;
    prev_mode_d = mode_cur;

    state_d      = ST_IDLE;
    addr_d       = addr_q;
    ce_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    we_n_d       = 1'b1;
    lb_n_d       = 1'b1;
    ub_n_d       = 1'b1;
    dq_o_d       = dq_o_q;
    dq_oe_d      = 1'b0;
    pend_d       = 1'b0;
    pend_addr_d  = pend_addr_q;
    pend_lanes_d = pend_lanes_q;
    issue        = 1'b0;
    issue_lanes  = 2'b00;

    if (pend_q) begin
      // Drain the delayed read; a read arriving now takes its place so a
      // stream after a turnaround stays one read per cycle. The sequencer
      // separates the last read and the next write by an idle cycle.
      state_d     = ST_READ;
      addr_d      = pend_addr_q;
      ce_n_d      = 1'b0;
      oe_n_d      = 1'b0;
      lb_n_d      = ~pend_lanes_q[0];
      ub_n_d      = ~pend_lanes_q[1];
      issue       = 1'b1;
      issue_lanes = pend_lanes_q;
      if (mode_cur == MODE_READ) begin
        pend_d       = 1'b1;
        pend_addr_d  = rd_addr;
        pend_lanes_d = rd_lanes(rdSramCount);
      end
    end else if (phase_start) begin
      // Use the next write address so a phase starting on the same edge as
      // an increment or clear already sees the updated value.
      state_d = ST_WR_SETUP;
      addr_d  = wr_addr_d;
      ce_n_d  = 1'b0;
      dq_oe_d = 1'b1;
      lb_n_d  = (mode_cur == MODE_WR_UB);
      ub_n_d  = (mode_cur == MODE_WR_LB);
      dq_o_d  = {wr_byte, wr_byte};
    end else if (mode_cur == MODE_READ) begin
      if (dq_oe_q) begin
        // Bus still driven by us: one cycle with everything released.
        state_d      = ST_TURN;
        pend_d       = 1'b1;
        pend_addr_d  = rd_addr;
        pend_lanes_d = rd_lanes(rdSramCount);
      end else begin
        state_d     = ST_READ;
        addr_d      = rd_addr;
        ce_n_d      = 1'b0;
        oe_n_d      = 1'b0;
        lb_n_d      = ~rd_lanes(rdSramCount)[0];
        ub_n_d      = ~rd_lanes(rdSramCount)[1];
        issue       = 1'b1;
        issue_lanes = rd_lanes(rdSramCount);
      end
    end else if (in_wr && is_wr) begin
      // Same write code held: strobe once right after setup, then hold data
      // with we_n high until the phase changes.
      state_d = ST_WR_STROBE;
      ce_n_d  = 1'b0;
      dq_oe_d = 1'b1;
      we_n_d  = (state_q != ST_WR_SETUP);
      lb_n_d  = lb_n_q;
      ub_n_d  = ub_n_q;
    end
  end

  always_ff @(posedge clk100m) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prev_mode_q  <= MODE_IDLE;
      addr_q       <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      lb_n_q       <= 1'b1;
      ub_n_q       <= 1'b1;
      dq_o_q       <= 16'h0000;
      dq_oe_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_done_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_lanes_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      prev_mode_q  <= prev_mode_d;
      addr_q       <= addr_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      lb_n_q       <= lb_n_d;
      ub_n_q       <= ub_n_d;
      dq_o_q       <= dq_o_d;
      dq_oe_q      <= dq_oe_d;
      wr_addr_q    <= wr_addr_d;
      wr_done_q    <= wr_done_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_lanes_q <= pend_lanes_d;
    end
  end

  assign sram.sram_addr  = addr_q;
  assign sram.sram_ce_n  = ce_n_q;
  assign sram.sram_oe_n  = oe_n_q;
  assign sram.sram_we_n  = we_n_q;
  assign sram.sram_lb_n  = lb_n_q;
  assign sram.sram_ub_n  = ub_n_q;
  assign sram.sram_dq_o  = dq_o_q;
  assign sram.sram_dq_oe = dq_oe_q;
  assign wr_done         = wr_done_q;

  sram_rd_capture u_capture (
    .clk100m     (clk100m),
    .rst         (rst),
    .issue       (issue),
    .issue_lanes (issue_lanes),
    .dq_i        (sram.sram_dq_i),
    .rd_data     (rd_data),
    .rd_mask     (rd_mask),
    .rd_valid    (rd_valid)
  );
endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: bench for sram_port_ctrl with a behavioural SRAM model.
// Two instances share the command inputs: AW=20 for most scenarios and AW=4
// for address wrap.
module tb_sram_port_ctrl;
  import sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  mode = 3'b000;
  logic [1:0]  cnt = 2'b00;
  logic [19:0] rd_addr = 20'h0;
  logic        wr_start = 1'b0;
  logic [7:0]  wr_byte = 8'h00;
  logic [15:0] rd_data, rd_data4;
  logic [1:0]  rd_mask, rd_mask4;
  logic        rd_valid, rd_valid4, wr_done, wr_done4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_ctrl_if #(.AW(20)) sif ();
  sram_port_ctrl_if #(.AW(4))  sif4 ();

  sram_port_ctrl #(.AW(20)) dut (
    .clk100m(clk), .rst(rst), .mode(mode), .rdSramCount(cnt), .rd_addr(rd_addr),
    .wr_start(wr_start), .wr_byte(wr_byte), .sram(sif),
    .rd_data(rd_data), .rd_mask(rd_mask), .rd_valid(rd_valid), .wr_done(wr_done)
  );

  sram_port_ctrl #(.AW(4)) dut4 (
    .clk100m(clk), .rst(rst), .mode(mode), .rdSramCount(cnt), .rd_addr(rd_addr[3:0]),
    .wr_start(wr_start), .wr_byte(wr_byte), .sram(sif4),
    .rd_data(rd_data4), .rd_mask(rd_mask4), .rd_valid(rd_valid4), .wr_done(wr_done4)
  );

  // ---------------- SRAM model ----------------
  logic [15:0] mem [256];
  logic        mem_vld [256];
  logic [15:0] mem4 [16];
  int          we_low_cnt = 0;

  // Contents of never-written words; address 0x10 yields 0xA55A.
  function automatic logic [15:0] pattern(input logic [19:0] a);
    return 16'hA55A ^ {a[7:0], a[7:0]} ^ 16'h1010;
  endfunction

  assign sif.sram_dq_i = (!sif.sram_ce_n && !sif.sram_oe_n) ?
      (mem_vld[sif.sram_addr[7:0]] ? mem[sif.sram_addr[7:0]] : pattern(sif.sram_addr)) : 16'h0000;
  assign sif4.sram_dq_i = (!sif4.sram_ce_n && !sif4.sram_oe_n) ? mem4[sif4.sram_addr] : 16'h0000;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_vld[i] = 1'b0;
      for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
    end else begin
      if (!sif.sram_ce_n && !sif.sram_we_n && sif.sram_dq_oe) begin
        logic [15:0] w;
        w = mem_vld[sif.sram_addr[7:0]] ? mem[sif.sram_addr[7:0]] : pattern(sif.sram_addr);
        if (!sif.sram_lb_n) w[7:0]  = sif.sram_dq_o[7:0];
        if (!sif.sram_ub_n) w[15:8] = sif.sram_dq_o[15:8];
        mem[sif.sram_addr[7:0]]     = w;
        mem_vld[sif.sram_addr[7:0]] = 1'b1;
        we_low_cnt++;
      end
      if (!sif4.sram_ce_n && !sif4.sram_we_n && sif4.sram_dq_oe) begin
        if (!sif4.sram_lb_n) mem4[sif4.sram_addr][7:0]  = sif4.sram_dq_o[7:0];
        if (!sif4.sram_ub_n) mem4[sif4.sram_addr][15:8] = sif4.sram_dq_o[15:8];
      end
    end
  end

  // {ce_n, oe_n, we_n, lb_n, ub_n, dq_oe}
  wire [5:0] strb = {sif.sram_ce_n, sif.sram_oe_n, sif.sram_we_n,
                     sif.sram_lb_n, sif.sram_ub_n, sif.sram_dq_oe};
  localparam logic [5:0] S_IDLE = 6'b111110;

  function automatic logic [1:0] lanes_ref(input logic [1:0] c);
    return (c == 2'b01) ? 2'b01 : ((c == 2'b10) ? 2'b10 : 2'b11);
  endfunction
  function automatic logic [5:0] s_read(input logic [1:0] m);
    return {3'b001, ~m[0], ~m[1], 1'b0};
  endfunction
  function automatic logic [5:0] s_wr(input logic ub, input logic strobe);
    return {2'b01, ~strobe, ub, ~ub, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_phase(input logic [2:0] m, input logic [7:0] b);
    mode = m; wr_byte = b;
    tick();
    wr_byte = 8'($urandom);
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; mode = 3'b010; cnt = 2'b11; rd_addr = 20'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (strb !== S_IDLE) begin errors++; $display("FAIL reset_strobes cyc%0d got %b exp %b", i, strb, S_IDLE); end
      checks++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid cyc%0d got %b exp 0", i, rd_valid); end
    end
    checks++;
    if ({sif.sram_addr, sif.sram_dq_o, rd_data, rd_mask, wr_done} !== 55'h0)
      begin errors++; $display("FAIL reset_regs addr=%h dq_o=%h rd_data=%h mask=%b wr_done=%b exp all 0",
                               sif.sram_addr, sif.sram_dq_o, rd_data, rd_mask, wr_done); end
    rst = 1'b0; mode = 3'b000;
    tick();
    checks++;
    if (strb !== S_IDLE || rd_valid !== 1'b0)
      begin errors++; $display("FAIL reset_release strb=%b rd_valid=%b exp %b/0", strb, rd_valid, S_IDLE); end
    $display("reset done");
  endtask

  task automatic test_read_lanes();
    mode = 3'b010; rd_addr = 20'h00010; cnt = 2'b01;
    tick();
    checks++;
    if (strb !== 6'b001010 || sif.sram_addr !== 20'h00010)
      begin errors++; $display("FAIL lanes_pins strb=%b addr=%h exp 001010/00010", strb, sif.sram_addr); end
    mode = 3'b000;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h005A || rd_mask !== 2'b01)
      begin errors++; $display("FAIL lanes_data valid=%b data=%h mask=%b exp 1/005a/01", rd_valid, rd_data, rd_mask); end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL lanes_pulse valid=%b exp 0", rd_valid); end
    $display("rd addr=00010 mask=%b data=%h", rd_mask, rd_data);
  endtask

  task automatic test_read_stream();
    logic [2:0]  idle_codes [5];
    logic        prev_rd;
    logic [19:0] prev_a;
    logic [1:0]  prev_c;
    idle_codes = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b111};
    prev_rd = 1'b0; prev_a = '0; prev_c = '0;
    for (int i = 0; i <= 40; i++) begin
      logic        do_rd;
      logic [1:0]  c;
      logic [19:0] a;
      if (i < 4) begin
        do_rd = 1'b1; c = 2'(i); a = 20'(i);
      end else if (i == 40) begin
        do_rd = 1'b0; c = 2'b00; a = '0;
      end else begin
        do_rd = ($urandom_range(0, 3) != 0);
        c = 2'($urandom);
        a = 20'h40 + 20'($urandom_range(0, 127));
      end
      mode = do_rd ? 3'b010 : idle_codes[$urandom_range(0, 4)];
      cnt = c; rd_addr = a;
      tick();
      checks++;
      if (do_rd) begin
        if (strb !== s_read(lanes_ref(c)) || sif.sram_addr !== a)
          begin errors++; $display("FAIL stream_pins i=%0d strb=%b addr=%h exp %b/%h", i, strb, sif.sram_addr, s_read(lanes_ref(c)), a); end
      end else if (strb !== S_IDLE) begin
        errors++; $display("FAIL stream_idle i=%0d mode=%b strb=%b exp %b", i, mode, strb, S_IDLE);
      end
      checks++;
      if (rd_valid !== prev_rd) begin
        errors++; $display("FAIL stream_valid i=%0d got %b exp %b", i, rd_valid, prev_rd);
      end else if (prev_rd) begin
        logic [1:0]  m;
        logic [15:0] e;
        m = lanes_ref(prev_c);
        e = pattern(prev_a) & {{8{m[1]}}, {8{m[0]}}};
        checks++;
        if (rd_data !== e || rd_mask !== m)
          begin errors++; $display("FAIL stream_data i=%0d data=%h mask=%b exp %h/%b", i, rd_data, rd_mask, e, m); end
        $display("rd addr=%h mask=%b data=%h", prev_a, rd_mask, rd_data);
      end
      prev_rd = do_rd; prev_a = a; prev_c = c;
    end
  endtask

  task automatic test_write_seq();
    int snap;
    mode = 3'b000; wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    snap = we_low_cnt;
    mode = 3'b100; wr_byte = 8'h34;
    tick();
    checks++;
    if (strb !== s_wr(1'b0, 1'b0) || sif.sram_addr !== 20'h0 || sif.sram_dq_o !== 16'h3434)
      begin errors++; $display("FAIL wr_lb_setup strb=%b addr=%h dq=%h exp %b/0/3434", strb, sif.sram_addr, sif.sram_dq_o, s_wr(1'b0, 1'b0)); end
    wr_byte = 8'($urandom);
    tick();
    checks++;
    if (strb !== s_wr(1'b0, 1'b1) || sif.sram_dq_o !== 16'h3434)
      begin errors++; $display("FAIL wr_lb_strobe strb=%b dq=%h exp %b/3434", strb, sif.sram_dq_o, s_wr(1'b0, 1'b1)); end
    mode = 3'b101; wr_byte = 8'h12;
    tick();
    checks++;
    if (strb !== s_wr(1'b1, 1'b0) || sif.sram_addr !== 20'h0 || sif.sram_dq_o !== 16'h1212 || wr_done !== 1'b0)
      begin errors++; $display("FAIL wr_ub_setup strb=%b addr=%h dq=%h done=%b exp %b/0/1212/0", strb, sif.sram_addr, sif.sram_dq_o, wr_done, s_wr(1'b1, 1'b0)); end
    wr_byte = 8'($urandom);
    tick();
    checks++;
    if (strb !== s_wr(1'b1, 1'b1)) begin errors++; $display("FAIL wr_ub_strobe strb=%b exp %b", strb, s_wr(1'b1, 1'b1)); end
    mode = 3'b000;
    tick();
    checks++;
    if (strb !== S_IDLE || wr_done !== 1'b1)
      begin errors++; $display("FAIL wr_to_idle strb=%b done=%b exp %b/1", strb, wr_done, S_IDLE); end
    tick();
    checks++;
    if (wr_done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse got %b exp 0", wr_done); end
    checks++;
    if (we_low_cnt - snap !== 2) begin errors++; $display("FAIL wr_we_count got %0d exp 2", we_low_cnt - snap); end
    checks++;
    if (mem[0] !== 16'h1234) begin errors++; $display("FAIL wr_word0 got %h exp 1234", mem[0]); end
    $display("wr addr=0 word=%h", mem[0]);
    mode = 3'b010; cnt = 2'b00; rd_addr = 20'h0;
    tick();
    mode = 3'b000;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h1234)
      begin errors++; $display("FAIL wr_readback valid=%b data=%h exp 1/1234", rd_valid, rd_data); end
    mode = 3'b100; wr_byte = 8'($urandom);
    tick();
    checks++;
    if (sif.sram_addr !== 20'h1) begin errors++; $display("FAIL wr_addr_next got %h exp 1", sif.sram_addr); end
    tick();
    mode = 3'b000;
    tick();
  endtask

  task automatic test_turnaround();
    logic [7:0]  b0, b1;
    logic [1:0]  c1, c2;
    logic [19:0] a1, a2;
    b0 = 8'($urandom); b1 = 8'($urandom);
    c1 = 2'($urandom); c2 = 2'($urandom);
    a1 = 20'h80 + 20'($urandom_range(0, 63));
    a2 = 20'hC0 + 20'($urandom_range(0, 63));
    mode = 3'b000; wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    drive_phase(3'b100, b0);
    drive_phase(3'b101, b1);
    mode = 3'b010; cnt = c1; rd_addr = a1;
    tick();
    checks++;
    if (strb !== S_IDLE || rd_valid !== 1'b0 || wr_done !== 1'b1)
      begin errors++; $display("FAIL turn_cycle strb=%b valid=%b done=%b exp %b/0/1", strb, rd_valid, wr_done, S_IDLE); end
    cnt = c2; rd_addr = a2;
    tick();
    checks++;
    if (strb !== s_read(lanes_ref(c1)) || sif.sram_addr !== a1 || rd_valid !== 1'b0)
      begin errors++; $display("FAIL turn_rd1_pins strb=%b addr=%h valid=%b exp %b/%h/0", strb, sif.sram_addr, rd_valid, s_read(lanes_ref(c1)), a1); end
    mode = 3'b000;
    tick();
    checks++;
    if (strb !== s_read(lanes_ref(c2)) || sif.sram_addr !== a2)
      begin errors++; $display("FAIL turn_rd2_pins strb=%b addr=%h exp %b/%h", strb, sif.sram_addr, s_read(lanes_ref(c2)), a2); end
    checks++;
    if (rd_valid !== 1'b1 || rd_mask !== lanes_ref(c1) ||
        rd_data !== (pattern(a1) & {{8{lanes_ref(c1)[1]}}, {8{lanes_ref(c1)[0]}}}))
      begin errors++; $display("FAIL turn_rd1_data valid=%b data=%h mask=%b exp 1/%h/%b", rd_valid, rd_data, rd_mask,
                               pattern(a1) & {{8{lanes_ref(c1)[1]}}, {8{lanes_ref(c1)[0]}}}, lanes_ref(c1)); end
    $display("rd addr=%h mask=%b data=%h (after turn)", a1, rd_mask, rd_data);
    tick();
    checks++;
    if (strb !== S_IDLE || rd_valid !== 1'b1 || rd_mask !== lanes_ref(c2) ||
        rd_data !== (pattern(a2) & {{8{lanes_ref(c2)[1]}}, {8{lanes_ref(c2)[0]}}}))
      begin errors++; $display("FAIL turn_rd2_data strb=%b valid=%b data=%h mask=%b exp %b/1/%h/%b", strb, rd_valid, rd_data, rd_mask, S_IDLE,
                               pattern(a2) & {{8{lanes_ref(c2)[1]}}, {8{lanes_ref(c2)[0]}}}, lanes_ref(c2)); end
    $display("rd addr=%h mask=%b data=%h", a2, rd_mask, rd_data);
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL turn_valid_end got %b exp 0", rd_valid); end
    checks++;
    if (mem[0] !== {b1, b0}) begin errors++; $display("FAIL turn_word0 got %h exp %h", mem[0], {b1, b0}); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp4 [16];
    mode = 3'b000; wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    for (int w = 0; w < 16; w++) begin
      exp4[w] = 16'($urandom);
      drive_phase(3'b100, exp4[w][7:0]);
      drive_phase(3'b101, exp4[w][15:8]);
      $display("wr4 addr=%0d word=%h", w, exp4[w]);
    end
    exp4[0][7:0] = 8'($urandom);
    mode = 3'b100; wr_byte = exp4[0][7:0];
    tick();
    checks++;
    if (sif4.sram_addr !== 4'h0 || sif.sram_addr !== 20'h10)
      begin errors++; $display("FAIL wrap_addr aw4=%h aw20=%h exp 0/10", sif4.sram_addr, sif.sram_addr); end
    tick();
    exp4[0][15:8] = 8'($urandom);
    drive_phase(3'b101, exp4[0][15:8]);
    // The UB increment of this word coincides with the clear.
    mode = 3'b000; wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    checks++;
    if (wr_done4 !== 1'b1) begin errors++; $display("FAIL wrap_done got %b exp 1", wr_done4); end
    mode = 3'b100; wr_byte = 8'h00;
    tick();
    checks++;
    if (sif4.sram_addr !== 4'h0 || sif.sram_addr !== 20'h0)
      begin errors++; $display("FAIL clear_wins aw4=%h aw20=%h exp 0/0", sif4.sram_addr, sif.sram_addr); end
    mode = 3'b000;
    tick();
    for (int w = 0; w < 16; w++) begin
      checks++;
      if (mem4[w] !== exp4[w]) begin errors++; $display("FAIL wrap_mem w=%0d got %h exp %h", w, mem4[w], exp4[w]); end
    end
  endtask

  task automatic test_reset_abort();
    mode = 3'b100; wr_byte = 8'($urandom);
    tick();
    tick();
    checks++;
    if (sif.sram_we_n !== 1'b0) begin errors++; $display("FAIL abort_pre_we got %b exp 0", sif.sram_we_n); end
    rst = 1'b1; mode = 3'b010;
    tick();
    checks++;
    if (strb !== S_IDLE) begin errors++; $display("FAIL abort_we strb=%b exp %b", strb, S_IDLE); end
    rst = 1'b0; mode = 3'b010; cnt = 2'b00; rd_addr = 20'h90;
    tick();
    rst = 1'b1; mode = 3'b000;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || strb !== S_IDLE)
      begin errors++; $display("FAIL abort_read valid=%b strb=%b exp 0/%b", rd_valid, strb, S_IDLE); end
    rst = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL abort_read_late valid=%b exp 0", rd_valid); end
    $display("reset abort done");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_read_lanes();
    test_read_stream();
    test_write_seq();
    test_turnaround();
    test_wrap();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
